// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock-divider bank.
package clk_div_pkg;

    typedef enum logic [2:0] {
        RST,
        ALIGN,
        SETTLE,
        RUN,
        PEND
    } state_e;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic logic cfg_legal(input int ch, input int div, input int phase,
                                       input int num_ch);
        return (ch < num_ch) && (div >= 2) && (phase < div);
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: wrap counter, ratio/phase registers and registered output.
module clk_div_ch #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             align_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [DIV_W-1:0] phase_i,
    output logic             tc_o,
    output logic             clk_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] phase_q;
    logic             clk_q;

    assign tc_o  = en_i && (cnt_q == div_q - DIV_W'(1));
    assign clk_o = clk_q;

    // A disabled channel parks at its phase so re-enable starts from there.
    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (align_i || !en_i) begin
            cnt_d = phase_q;
        end else if (cnt_q == div_q - DIV_W'(1)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q   <= '0;
            div_q   <= DIV_W'(DEFAULT_DIV);
            phase_q <= '0;
            clk_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= en_i && (cnt_q < (div_q >> 1));
            if (load_i) begin
                div_q   <= div_i;
                phase_q <= phase_i;
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of runtime-programmable clock dividers with a shared realign/lock sequencer.
// state  | meaning
// RST    | first cycle after reset release
// ALIGN  | all channel counters load their phase
// SETTLE | wait LOCK_CYCLES before declaring lock
// RUN    | locked, accepting configuration
// PEND   | config staged, waiting for target terminal count
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2,
    parameter int LOCK_CYCLES = 16,
    localparam int CH_W       = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked,
    output logic              cfg_err
);

    localparam int SET_W = $clog2(LOCK_CYCLES + 1);

    state_e            state_q, state_d;
    logic [SET_W-1:0]  settle_q;
    logic [CH_W-1:0]   sh_ch_q;
    logic [DIV_W-1:0]  sh_div_q;
    logic [DIV_W-1:0]  sh_phase_q;
    logic              locked_q;
    logic              cfg_err_q;
    logic              legal;
    logic              xfer;
    logic              align;
    logic              pend_load;
    logic [NUM_CH-1:0] tc;
    logic [NUM_CH-1:0] load;

    assign legal     = cfg_legal(int'(cfg_ch), int'(cfg_div), int'(cfg_phase), NUM_CH);
    assign xfer      = cfg_valid && cfg_ready;
    assign pend_load = |load;
    assign locked    = locked_q;
    assign cfg_err   = cfg_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RST:     state_d = ALIGN;
            ALIGN:   state_d = SETTLE;
            SETTLE:  if (settle_q == '0) state_d = RUN;
            RUN:     if (xfer && legal) state_d = PEND;
            PEND:    if (pend_load) state_d = ALIGN;
            default: state_d = RST;
        endcase
    end

    always_comb begin
        cfg_ready = (state_q == RUN);
        align     = (state_q == ALIGN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q   <= '0;
            sh_ch_q    <= '0;
            sh_div_q   <= '0;
            sh_phase_q <= '0;
            locked_q   <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            if (state_q == ALIGN) begin
                settle_q <= SET_W'(LOCK_CYCLES - 1);
            end else if (state_q == SETTLE && settle_q != '0) begin
                settle_q <= settle_q - SET_W'(1);
            end
            if (xfer && legal) begin
                sh_ch_q    <= cfg_ch;
                sh_div_q   <= cfg_div;
                sh_phase_q <= cfg_phase;
            end
            locked_q  <= (state_q == RUN) || (state_q == PEND);
            cfg_err_q <= xfer && !legal;
        end
    end

    // The target swaps ratio on its own terminal count, so its last old period is whole.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load[i] = (state_q == PEND) && (sh_ch_q == CH_W'(i)) && (tc[i] || !ch_en[i]);

        clk_div_ch #(
            .DIV_W      (DIV_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk_i  (clk),
            .rst_n_i(rst_n),
            .en_i   (ch_en[i]),
            .align_i(align),
            .load_i (load[i]),
            .div_i  (sh_div_q),
            .phase_i(sh_phase_q),
            .tc_o   (tc[i]),
            .clk_o  (clk_out[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench: timeline-based reference model plus directed and random configuration traffic.
module tb_clk_div_bank;

    localparam int NUM_CH      = 5;
    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 2;
    localparam int LOCK_CYCLES = 16;
    localparam int CH_W        = 3;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch    = '0;
    logic [DIV_W-1:0]  cfg_div   = '0;
    logic [DIV_W-1:0]  cfg_phase = '0;
    logic [NUM_CH-1:0] ch_en     = '1;
    logic [NUM_CH-1:0] clk_out;
    logic              locked;
    logic              cfg_err;

    always #5 clk = ~clk;

    clk_div_bank #(
        .NUM_CH     (NUM_CH),
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(DEFAULT_DIV),
        .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_phase(cfg_phase),
        .ch_en    (ch_en),
        .clk_out  (clk_out),
        .locked   (locked),
        .cfg_err  (cfg_err)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel's count is v + (edges since anchor a) mod div.
    int  m_n, m_align;
    int  m_div[NUM_CH], m_ph[NUM_CH], m_a[NUM_CH], m_v[NUM_CH];
    bit  m_pend, m_runlike;
    int  p_ch, p_div, p_ph;
    logic [NUM_CH-1:0] e_out    = '0;
    logic              e_locked = 1'b0;
    logic              e_ready  = 1'b0;
    logic              e_err    = 1'b0;

    task automatic model_reset();
        m_n = 0; m_align = 2; m_pend = 0; m_runlike = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i] = DEFAULT_DIV; m_ph[i] = 0; m_a[i] = 0; m_v[i] = 0;
        end
        e_out = '0; e_locked = 0; e_ready = 0; e_err = 0;
    endtask

    task automatic model_step();
        int c[NUM_CH];
        logic [NUM_CH-1:0] o;
        bit load_now, err;
        m_n++;
        for (int i = 0; i < NUM_CH; i++) begin
            c[i] = (m_v[i] + (m_n - 1 - m_a[i])) % m_div[i];
            o[i] = ch_en[i] && (c[i] < m_div[i] / 2);
        end
        load_now = m_pend && (!ch_en[p_ch] || c[p_ch] == m_div[p_ch] - 1);
        for (int i = 0; i < NUM_CH; i++)
            if (!ch_en[i]) begin m_a[i] = m_n; m_v[i] = m_ph[i]; end
        if (load_now) begin
            m_pend  = 0;
            m_align = m_n + 1;
            if (ch_en[p_ch]) begin m_a[p_ch] = m_n; m_v[p_ch] = 0; end
            m_div[p_ch] = p_div;
            m_ph[p_ch]  = p_ph;
        end
        if (m_n == m_align)
            for (int i = 0; i < NUM_CH; i++) begin m_a[i] = m_n; m_v[i] = m_ph[i]; end
        err = 0;
        if (e_ready && cfg_valid) begin
            if (int'(cfg_ch) < NUM_CH && cfg_div >= 2 && cfg_phase < cfg_div) begin
                m_pend = 1; p_ch = int'(cfg_ch); p_div = int'(cfg_div); p_ph = int'(cfg_phase);
            end else begin
                err = 1;
            end
        end
        e_locked  = m_runlike;
        m_runlike = (m_n >= m_align + LOCK_CYCLES);
        e_ready   = m_runlike && !m_pend;
        e_err     = err;
        e_out     = o;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        check("clk_out", 32'(clk_out), 32'(e_out));
        check("locked", 32'(locked), 32'(e_locked));
        check("cfg_ready", 32'(cfg_ready), 32'(e_ready));
        check("cfg_err", 32'(cfg_err), 32'(e_err));
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (cfg_err === 1'b1) err_cnt++;
    end

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic send(input int ch, input int d, input int p);
        int k;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = DIV_W'(d);
        cfg_phase = DIV_W'(p);
        for (k = 0; k < 400 && cfg_ready !== 1'b1; k++) @(negedge clk);
        check("send_ready_wait", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_relock();
        int k;
        bit seen;
        seen = 0;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!locked) seen = 1;
            else if (seen) break;
        end
        check("relock_wait", 32'(k < 400), 32'd1);
    endtask

    task automatic wait_locked();
        int k;
        for (k = 0; k < 400 && locked !== 1'b1; k++) @(negedge clk);
        check("lock_wait", 32'(locked), 32'd1);
    endtask

    task automatic count_high(input int ch, input int cycles, output int hi);
        hi = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (clk_out[ch]) hi++;
        end
    endtask

    initial begin
        int hi0, hi1, low, both, e0;
        logic p0, p1;
        logic [11:0] h2, h3;

        tick(3);
        rst_n = 1'b1;
        for (int k = 1; k <= LOCK_CYCLES + 3; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) check("reset_out_hi", 32'(clk_out), 32'h1f);
            if (k == 4) check("reset_out_lo", 32'(clk_out), 32'h00);
            if (k == LOCK_CYCLES + 2) check("lock_not_yet", 32'(locked), 32'd0);
            if (k == LOCK_CYCLES + 3) begin
                check("lock_edge", 32'(locked), 32'd1);
                check("ready_at_lock", 32'(cfg_ready), 32'd1);
            end
        end

        // ch1 -> div 5
        send(1, 5, 0);
        low = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!locked) low++;
            else if (low > 0) break;
        end
        check("relock_low_cycles", 32'(low), 32'(LOCK_CYCLES + 1));
        count_high(1, 10, hi1);
        check("ch1_div5_high", 32'(hi1), 32'd4);
        count_high(0, 10, hi0);
        check("ch0_div2_high", 32'(hi0), 32'd5);
        both = 0;
        @(negedge clk);
        p0 = clk_out[0]; p1 = clk_out[1];
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!p0 && clk_out[0] && !p1 && clk_out[1]) both++;
            p0 = clk_out[0]; p1 = clk_out[1];
        end
        check("coincident_rises", 32'(both), 32'd2);

        // ch3 div4 ph0, then ch2 div4 ph2
        send(3, 4, 0);
        wait_relock();
        send(2, 4, 2);
        wait_relock();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            h2[k] = clk_out[2]; h3[k] = clk_out[3];
        end
        for (int k = 2; k < 12; k++) check("ch2_lag2", 32'(h2[k]), 32'(h3[k-2]));

        // illegal requests
        e0 = err_cnt;
        send(0, 1, 0);
        tick(2);
        check("err_div1", 32'(err_cnt - e0), 32'd1);
        send(0, 6, 6);
        tick(2);
        check("err_phase", 32'(err_cnt - e0), 32'd2);
        send(NUM_CH, 3, 0);
        tick(2);
        check("err_ch", 32'(err_cnt - e0), 32'd3);
        check("locked_after_err", 32'(locked), 32'd1);

        // ch0 disabled for 7 cycles
        @(negedge clk);
        ch_en[0] = 1'b0;
        count_high(0, 7, hi0);
        check("ch0_disabled", 32'(hi0), 32'd0);
        ch_en[0] = 1'b1;
        @(posedge clk);
        #1;
        check("ch0_resume", 32'(clk_out[0]), 32'd1);

        // random traffic
        for (int it = 0; it < 25; it++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_CH; i++) ch_en[i] = ($urandom_range(0, 7) != 0);
            tick($urandom_range(0, 6));
            send($urandom_range(0, 6), $urandom_range(1, 9), $urandom_range(0, 9));
            tick($urandom_range(0, 30));
        end
        @(negedge clk);
        ch_en = '1;
        wait_locked();

        // reset while pending
        send(4, 50, 0);
        wait_relock();
        send(4, 3, 1);
        tick(3);
        check("pend_ready", 32'(cfg_ready), 32'd0);
        check("pend_locked", 32'(locked), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_out", 32'(clk_out), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        tick(2);
        rst_n = 1'b1;
        wait_locked();
        count_high(4, 10, hi0);
        check("ch4_default_after_rst", 32'(hi0), 32'd5);
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Parametrised successor to the board-level fixed clock-out test block.
- Generates NUM_CH divided clock-rate outputs from one input clock.
- Each channel has a runtime-programmable divide ratio and phase offset, applied glitch-free.
- Outputs are registered clock-rate signals for clock-enables, test pins and LEDs. They are not global clocks.
- Global lock/realign sequencer asserts `locked` once all enabled channels are phase-aligned and settled.

Parameters:
- NUM_CH, 4: number of output channels (1..16).
- DIV_W, 8: width of divide-ratio and phase fields.
- DEFAULT_DIV, 2: divide ratio of every channel after reset (2..2^DIV_W-1).
- LOCK_CYCLES, 16: settle cycles after alignment before `locked` asserts (>=1).

Ports:
- clk  input  1  input clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_valid  input  1  configuration request.
- cfg_ready  output  1  block can accept a configuration.
- cfg_ch  input  CH_W=max(1,$clog2(NUM_CH))  target channel.
- cfg_div  input  DIV_W  new divide ratio.
- cfg_phase  input  DIV_W  new phase offset, in input-clock cycles.
- ch_en  input  NUM_CH  per-channel run enable.
- clk_out  output  NUM_CH  divided outputs, registered.
- locked  output  1  all channels aligned and settled.
- cfg_err  output  1  one-cycle pulse on a rejected configuration.

Behaviour:
- One clock domain. Reset is asynchronous and active-low (`rst_n`); deassertion is assumed synchronised externally.
- Reset values:
  - clk_out=0, locked=0, cfg_ready=0, cfg_err=0.
  - All div regs = DEFAULT_DIV; all phase regs = 0; counters = 0; FSM = RST.
- Channel counter `cnt`:
  - Counts 0..div-1, then wraps to 0 (terminal count = cnt==div-1).
  - Next-state clk_out = (cnt < div>>1) ? 1 : 0, registered: one cycle of latency from cnt.
  - Odd div gives a low-biased duty cycle: high for floor(div/2) cycles.
- Global FSM: RST -> ALIGN -> SETTLE -> RUN, plus PEND.
  - RST: one cycle after reset release, then ALIGN.
  - ALIGN: one cycle. Every channel loads cnt=phase simultaneously; locked=0. Then SETTLE.
  - SETTLE: counts LOCK_CYCLES cycles, then RUN.
  - RUN: locked=1, cfg_ready=1.
  - Result: `locked` first rises on the (LOCK_CYCLES+3)rd rising edge after rst_n goes high.
- Config handshake:
  - Transfer occurs on cfg_valid & cfg_ready, in RUN only.
  - Legality: cfg_ch<NUM_CH, 2<=cfg_div, cfg_phase<cfg_div.
  - Illegal request: cfg_err=1 the next cycle; nothing staged; FSM stays in RUN.
  - Legal request: staged into shadow regs; FSM -> PEND; cfg_ready=0; locked stays 1.
  - Only one request may be outstanding at a time.
- PEND:
  - Waits for the target channel's terminal count.
  - On that cycle, loads div/phase from shadow; FSM -> ALIGN (bank-wide realign).
  - The target's last old-ratio period always completes, so there are no runt pulses.
  - If the target channel is disabled, the load happens on the next cycle.
- ch_en:
  - ch_en[i]=0 holds cnt[i]=phase[i] and clk_out[i]=0.
  - On re-enable, counting resumes from phase the next cycle, not aligned to other channels.
  - `locked` is unaffected by ch_en; software requests a realign by rewriting any channel's config.
- Mid-operation reset: async clear of all state to the reset values above, including discarding any pending shadow config.

Decomposition:
- Package `clk_div_pkg`:
  - FSM state enum (RST, ALIGN, SETTLE, RUN, PEND).
  - CH_W derivation function.
  - Legality-check function.
- Sub-module `clk_div_ch`: one counter, div/phase regs, enable and output register; instantiated NUM_CH times via generate.
- The top level holds the FSM, shadow regs, handshake and settle counter.

Test Plan:
1. Reset release, defaults: all clk_out toggle period 2 (1 high / 1 low, in phase); locked rises exactly LOCK_CYCLES+3 edges after rst_n high; cfg_ready=1 from then on.
2. Program ch1 div=5 phase=0 -> ch1 current period completes; locked drops for LOCK_CYCLES+1 cycles; then ch1 runs 2 high / 3 low, ch0 still period 2; ch0/ch1 rising edges coincide every 10 cycles.
3. Program ch2 div=4 phase=2 after ch3 div=4 phase=0 -> ch2 lags ch3 by exactly 2 cycles after the realign.
4. Illegal requests cfg_div=1, cfg_phase=6 with cfg_div=6, cfg_ch=NUM_CH -> one cfg_err pulse each; no output change; locked stays 1.
5. ch_en[0]=0 for 7 cycles -> clk_out[0]=0 throughout; on re-enable, counting resumes from phase; other channels undisturbed.
6. Assert rst_n=0 while in PEND -> outputs immediately 0, locked=0; after release, all channels run DEFAULT_DIV and the staged config is lost.
